// File: rtl/poly_stream_io.sv
// poly_stream_io: host-side streaming adapter for the Kyber polynomial core.
// Load packs 12-bit coefficients into 48-bit words for the core's coefficient
// RAM; unload captures the core's 32-word read burst and replays it as a
// coefficient stream.
// Optional feature: define POLY_STREAM_IO_RANGE_CHECK_EN to reduce loaded
// coefficients >= Q by Q and raise the sticky range_err flag.

module poly_stream_io #(
    parameter int WID    = 12,
    parameter int DWID   = 48,
    parameter int AWID   = 5,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_load,
    input  logic            cmd_unload,
    output logic            busy,
    input  logic [WID-1:0]  s_coef,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [WID-1:0]  m_coef,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            range_err,
    output logic [DWID-1:0] core_data_in,
    output logic [AWID-1:0] core_data_in_add,
    output logic            core_data_in_done,
    input  logic [DWID-1:0] core_data_out,
    output logic [1:0]      core_mode,
    output logic            core_run,
    input  logic            core_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        LDONE,
        URUN,
        UCAP,
        USTREAM
    } state_t;

    localparam logic [1:0] MODE_DATAIN  = 2'd2;
    localparam logic [1:0] MODE_DATAOUT = 2'd3;
    localparam logic [6:0] CNT_LAST     = 7'd127;

    state_t            state;
    state_t            state_next;
    logic [6:0]        cnt;
    logic              flush_tick;
    logic              done_seen;
    logic              drained;
    logic [3*WID-1:0]  lane_acc;
    logic [DWID-1:0]   buffer [32];
    logic [DWID-1:0]   cur_word;
    logic [WID-1:0]    coef_in;
    logic              s_accept;
    logic              m_accept;
    logic              cap_fire;
    logic [AWID-1:0]   cap_pos;
    logic              cmd_take;

    assign cmd_take = (state == IDLE) && (cmd_load || cmd_unload);
    assign s_accept = (state == LOAD) && s_valid;
    assign m_accept = m_valid && m_ready;
    // The capture counter runs from the URUN edge; the first RD_LAT ticks are
    // the core's read latency before word 0 appears.
    assign cap_fire = (state == UCAP) && (cnt >= 7'(RD_LAT));
    assign cap_pos  = AWID'(cnt - 7'(RD_LAT));
    assign cur_word = buffer[cnt[6:2]];

`ifdef POLY_STREAM_IO_RANGE_CHECK_EN
    localparam logic [WID-1:0] Q = WID'(3329);

    assign coef_in = (s_coef >= Q) ? (s_coef - Q) : s_coef;

    // Sticky out-of-range flag, cleared only by reset or a new load command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err <= 1'b0;
        end else if ((state == IDLE) && cmd_load) begin
            range_err <= 1'b0;
        end else if (s_accept && (s_coef >= Q)) begin
            range_err <= 1'b1;
        end
    end
`else
    assign coef_in   = s_coef;
    assign range_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the status/handshake outputs that follow the state.
    always_comb begin
        state_next        = state;
        busy              = 1'b1;
        s_ready           = 1'b0;
        m_valid           = 1'b0;
        core_data_in_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cmd_load) begin
                    state_next = LOAD;
                end else if (cmd_unload) begin
                    state_next = URUN;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_accept && (cnt == CNT_LAST)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_tick) begin
                    state_next = LDONE;
                end
            end
            LDONE: begin
                core_data_in_done = 1'b1;
                if (core_done) begin
                    state_next = IDLE;
                end
            end
            URUN: begin
                state_next = UCAP;
            end
            UCAP: begin
                if (cap_fire && (cap_pos == '1)) begin
                    state_next = USTREAM;
                end
            end
            USTREAM: begin
                m_valid = !drained;
                if ((drained || (m_accept && (cnt == CNT_LAST))) &&
                    (done_seen || core_done)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Lane select for the outgoing coefficient; forced to 0 when not valid.
    always_comb begin
        m_coef = '0;
        if (m_valid) begin
            case (cnt[1:0])
                2'd0:    m_coef = cur_word[WID-1:0];
                2'd1:    m_coef = cur_word[2*WID-1:WID];
                2'd2:    m_coef = cur_word[3*WID-1:2*WID];
                default: m_coef = cur_word[4*WID-1:3*WID];
            endcase
        end
    end

    // Shared coefficient/tick counter: load index, capture tick, stream index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_take) begin
                        cnt <= '0;
                    end
                end
                LOAD: begin
                    if (s_valid && (cnt != CNT_LAST)) begin
                        cnt <= cnt + 7'd1;
                    end
                end
                URUN: begin
                    cnt <= '0;
                end
                UCAP: begin
                    if (cap_fire && (cap_pos == '1)) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                USTREAM: begin
                    if (m_accept && (cnt != CNT_LAST)) begin
                        cnt <= cnt + 7'd1;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Command bookkeeping: mode latch, one-cycle run pulse, done latch,
    // stream-drained flag and the two-cycle flush timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_mode  <= 2'd0;
            core_run   <= 1'b0;
            done_seen  <= 1'b0;
            drained    <= 1'b0;
            flush_tick <= 1'b0;
        end else begin
            core_run   <= cmd_take;
            flush_tick <= (state == FLUSH) ? !flush_tick : 1'b0;
            if (state == IDLE) begin
                done_seen <= 1'b0;
                drained   <= 1'b0;
                if (cmd_load) begin
                    core_mode <= MODE_DATAIN;
                end else if (cmd_unload) begin
                    core_mode <= MODE_DATAOUT;
                end
            end else begin
                if (((state == UCAP) || (state == USTREAM)) && core_done) begin
                    done_seen <= 1'b1;
                end
                if ((state == USTREAM) && m_accept && (cnt == CNT_LAST)) begin
                    drained <= 1'b1;
                end
            end
        end
    end

    // Word packing; the core-facing word and address update together on the
    // fourth lane and otherwise hold so repeated core writes are harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_acc         <= '0;
            core_data_in     <= '0;
            core_data_in_add <= '0;
        end else if (s_accept) begin
            case (cnt[1:0])
                2'd0:    lane_acc[WID-1:0]       <= coef_in;
                2'd1:    lane_acc[2*WID-1:WID]   <= coef_in;
                2'd2:    lane_acc[3*WID-1:2*WID] <= coef_in;
                default: begin
                    core_data_in     <= {coef_in, lane_acc};
                    core_data_in_add <= cnt[6:2];
                end
            endcase
        end
    end

    // Unload capture buffer; its contents need no reset because the stream
    // only reads words captured during the current unload.
    always_ff @(posedge clk) begin
        if (cap_fire) begin
            buffer[cap_pos] <= core_data_out;
        end
    end

endmodule

// File: tb/tb_poly_stream_io.sv
// tb_poly_stream_io: directed bench for poly_stream_io with a small core
// model (coefficient RAM, write-while-DATAIN, 32-word read burst, done pulse).
// Build with POLY_STREAM_IO_RANGE_CHECK_EN to expect the range-reduced values.

module tb_poly_stream_io;

    localparam int WID  = 12;
    localparam int DWID = 48;
    localparam int AWID = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_load = 1'b0;
    logic            cmd_unload = 1'b0;
    logic            busy;
    logic [WID-1:0]  s_coef = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [WID-1:0]  m_coef;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic            range_err;
    logic [DWID-1:0] core_data_in;
    logic [AWID-1:0] core_data_in_add;
    logic            core_data_in_done;
    logic [DWID-1:0] core_data_out = '0;
    logic [1:0]      core_mode;
    logic            core_run;
    logic            core_done = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    poly_stream_io dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_load          (cmd_load),
        .cmd_unload        (cmd_unload),
        .busy              (busy),
        .s_coef            (s_coef),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .m_coef            (m_coef),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .range_err         (range_err),
        .core_data_in      (core_data_in),
        .core_data_in_add  (core_data_in_add),
        .core_data_in_done (core_data_in_done),
        .core_data_out     (core_data_out),
        .core_mode         (core_mode),
        .core_run          (core_run),
        .core_done         (core_done)
    );

    // Core model: RAM written every cycle in DATAIN mode, read burst after a
    // DATAOUT run pulse (one cycle read latency), done pulse after each job.
    logic [DWID-1:0] ram [32];
    logic            reading = 1'b0;
    logic [5:0]      rd_addr = '0;
    logic            wipe = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
    end

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (wipe) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
        end else if (busy && (core_mode == 2'd2)) begin
            ram[core_data_in_add] <= core_data_in;
        end
        if (core_data_in_done && !core_done) core_done <= 1'b1;
        if (rst) begin
            reading <= 1'b0;
        end else if (core_run && (core_mode == 2'd3)) begin
            reading <= 1'b1;
            rd_addr <= '0;
        end else if (reading) begin
            core_data_out <= ram[rd_addr[4:0]];
            rd_addr       <= rd_addr + 6'd1;
            if (rd_addr == 6'd31) begin
                reading   <= 1'b0;
                core_done <= 1'b1;
            end
        end
    end

    function automatic logic [DWID-1:0] exp_word(input int k);
        exp_word = {WID'(4*k+3), WID'(4*k+2), WID'(4*k+1), WID'(4*k)};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int k = 0; k < 32; k++) check_output(tag, 64'(ram[k]), 64'(exp_word(k)));
    endtask

    // Load 128 coefficients (value = index, except bad_idx gets 4000).
    // Times are cycle numbers counted from the command-sampling edge.
    task automatic apply_load(input bit toggle, input int bad_idx, input int abort_at,
                              output int t_done, output int t_idle, output int moves);
        int idx;
        int n;
        bit acc;
        logic [AWID-1:0] prev_add;
        idx = 0; n = 0; t_done = -1; t_idle = -1; moves = 0;
        @(negedge clk);
        cmd_load = 1'b1;
        s_valid  = 1'b0;
        @(posedge clk);
        #1 cmd_load = 1'b0;
        prev_add = core_data_in_add;
        while ((t_idle < 0) && (n < 400)) begin
            @(negedge clk);
            s_valid = (idx < 128) && (!toggle || (n % 2 == 0));
            s_coef  = (idx == bad_idx) ? WID'(4000) : WID'(idx);
            if (n == 0) begin
                check_output("load_run_first", 64'(core_run), 64'd1);
                check_output("load_ready", 64'(s_ready), 64'd1);
                check_output("load_mode", 64'(core_mode), 64'd2);
                check_output("load_err_clear", 64'(range_err), 64'd0);
            end
            if (n == 1) check_output("load_run_once", 64'(core_run), 64'd0);
            if (core_data_in_add != prev_add) begin
                moves++;
                check_output("addr_step", 64'(idx), 64'(4 * (core_data_in_add + 1)));
                prev_add = core_data_in_add;
            end
            if (core_data_in_done && (t_done < 0)) t_done = n + 1;
            if (!busy) t_idle = n + 1;
            if ((abort_at >= 0) && (idx == abort_at)) begin
                rst = 1'b1;
                #1;
                check_output("rst_outputs",
                    64'({busy, s_ready, m_valid, m_coef, range_err, core_data_in_add,
                         core_data_in_done, core_mode, core_run}), 64'd0);
                check_output("rst_data_in", 64'(core_data_in), 64'd0);
                break;
            end
            acc = s_valid && s_ready;
            @(posedge clk);
            n++;
            if (acc) idx++;
        end
        s_valid = 1'b0;
    endtask

    // Unload and check every streamed coefficient; m_ready drops for 5
    // cycles when the stream reaches stall_at.
    task automatic apply_unload(input int stall_at, output int t_first,
                                output int t_idle, output int count);
        int idx;
        int n;
        int stall_left;
        bit hs;
        idx = 0; n = 0; stall_left = 5; t_first = -1; t_idle = -1;
        @(negedge clk);
        cmd_unload = 1'b1;
        @(posedge clk);
        #1 cmd_unload = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            if (n == 0) begin
                check_output("unload_run", 64'(core_run), 64'd1);
                check_output("unload_mode", 64'(core_mode), 64'd3);
                check_output("unload_busy", 64'(busy), 64'd1);
            end
            m_ready = 1'b1;
            if ((idx == stall_at) && (stall_left > 0)) begin
                m_ready = 1'b0;
                stall_left--;
            end
            if (m_valid) begin
                if (t_first < 0) t_first = n + 1;
                check_output("m_coef", 64'(m_coef), 64'(idx));
            end
            if (!busy) begin
                t_idle = n + 1;
                break;
            end
            hs = m_valid && m_ready;
            @(posedge clk);
            n++;
            if (hs) idx++;
        end
        m_ready = 1'b0;
        count = idx;
    endtask

    initial begin
        int t_done;
        int t_idle;
        int t_first;
        int moves;
        int count;

        $display("[TB] reset");
        #3 rst = 1'b1;
        #1;
        check_output("reset_outputs",
            64'({busy, s_ready, m_valid, m_coef, range_err, core_data_in_add,
                 core_data_in_done, core_mode, core_run}), 64'd0);
        check_output("reset_data_in", 64'(core_data_in), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] load, continuous input");
        apply_load(1'b0, -1, -1, t_done, t_idle, moves);
        check_output("done_cycle", 64'(t_done), 64'd131);
        check_output("idle_cycle", 64'(t_idle), 64'd133);
        check_output("addr_moves", 64'(moves), 64'd31);
        check_output("last_addr", 64'(core_data_in_add), 64'd31);
        check_ram("ram_cont");

        $display("[TB] load, toggling input");
        @(negedge clk); wipe = 1'b1;
        @(negedge clk); wipe = 1'b0;
        apply_load(1'b1, -1, -1, t_done, t_idle, moves);
        check_output("toggle_idle", 64'(t_idle > 0), 64'd1);
        check_output("toggle_moves", 64'(moves), 64'd32);
        check_ram("ram_toggle");

        $display("[TB] unload, m_ready high");
        apply_unload(-1, t_first, t_idle, count);
        check_output("first_valid", 64'(t_first), 64'd35);
        check_output("unload_count", 64'(count), 64'd128);
        check_output("unload_idle", 64'(t_idle), 64'd163);

        $display("[TB] unload, stall at 60");
        apply_unload(60, t_first, t_idle, count);
        check_output("stall_first_valid", 64'(t_first), 64'd35);
        check_output("stall_count", 64'(count), 64'd128);
        check_output("stall_idle", 64'(t_idle), 64'd168);

        $display("[TB] load with 4000 at index 7");
        apply_load(1'b0, 7, -1, t_done, t_idle, moves);
        check_output("range_idle", 64'(t_idle), 64'd133);
`ifdef POLY_STREAM_IO_RANGE_CHECK_EN
        check_output("range_lane", 64'(ram[1][47:36]), 64'd671);
        check_output("range_err", 64'(range_err), 64'd1);
`else
        check_output("range_lane", 64'(ram[1][47:36]), 64'd4000);
        check_output("range_err", 64'(range_err), 64'd0);
`endif
        check_output("range_word0", 64'(ram[0]), 64'(exp_word(0)));
        check_output("range_word2", 64'(ram[2]), 64'(exp_word(2)));

        $display("[TB] reset at coefficient 50");
        apply_load(1'b0, -1, 50, t_done, t_idle, moves);
        check_output("abort_no_done", 64'(t_done), 64'hffff_ffff_ffff_ffff);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("abort_idle", 64'(busy), 64'd0);

        $display("[TB] unload after reset");
        apply_unload(-1, t_first, t_idle, count);
        check_output("post_rst_first", 64'(t_first), 64'd35);
        check_output("post_rst_count", 64'(count), 64'd128);
        check_output("post_rst_idle", 64'(t_idle), 64'd163);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
